// File: rtl/parking_duration_tracker.sv
// Multi-slot parking stay-time engine.
// A prescaled free-running time base stamps each slot on entry. On exit, the
// elapsed time (now - stamp, modulo 2^TIME_W) is reported one clock later.
// A sticky per-slot flag records stays that reached a full time-base period.
module parking_duration_tracker #(
   parameter int unsigned TIME_W   = 8,
   parameter int unsigned SLOTS    = 4,
   parameter int unsigned SLOT_W   = 2,
   parameter int unsigned TICK_DIV = 1,
   parameter bit          SATURATE = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enter_valid,
   input  logic [SLOT_W-1:0] i_enter_slot,
   input  logic              i_exit_valid,
   input  logic [SLOT_W-1:0] i_exit_slot,
   output logic [TIME_W-1:0] o_now_time,
   output logic [SLOTS-1:0]  o_occupied,
   output logic              o_dur_valid,
   output logic [SLOT_W-1:0] o_dur_slot,
   output logic [TIME_W-1:0] o_dur_time,
   output logic              o_dur_wrap,
   output logic              o_err
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PRE_W-1:0]  r_presc;
   logic [TIME_W-1:0] r_now;
   logic [TIME_W-1:0] r_stamp [SLOTS];
   logic [SLOTS-1:0]  r_wrap;
   logic [SLOTS-1:0]  r_occ;
   logic              r_dur_valid;
   logic [SLOT_W-1:0] r_dur_slot;
   logic [TIME_W-1:0] r_dur_time;
   logic              r_dur_wrap;
   logic              r_err;

   logic              w_tick;
   logic [TIME_W-1:0] w_now_inc;
   logic              w_enter_range;
   logic              w_exit_range;
   logic              w_exit_ok;
   logic              w_same_slot;
   logic              w_enter_ok;
   logic              w_err;
   logic [TIME_W-1:0] w_raw;
   logic [TIME_W-1:0] w_dur;

   assign w_tick    = (r_presc == PRE_W'(TICK_DIV - 1));
   assign w_now_inc = r_now + TIME_W'(1);

   assign w_enter_range = (32'(i_enter_slot) < SLOTS);
   assign w_exit_range  = (32'(i_exit_slot) < SLOTS);

   assign w_exit_ok   = i_exit_valid & w_exit_range & r_occ[i_exit_slot];
   // Entering a slot that is being vacated on the same edge is a legal re-stamp.
   assign w_same_slot = w_exit_ok & (i_enter_slot == i_exit_slot);
   assign w_enter_ok  = i_enter_valid & w_enter_range & (~r_occ[i_enter_slot] | w_same_slot);
   assign w_err       = (i_enter_valid & ~w_enter_ok) | (i_exit_valid & ~w_exit_ok);

   assign w_raw = r_now - r_stamp[i_exit_slot];
   assign w_dur = (SATURATE && r_wrap[i_exit_slot]) ? '1 : w_raw;

   // Time base: prescaler and now counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_presc <= '0;
         r_now   <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
         r_now   <= w_now_inc;
      end else begin
         r_presc <= r_presc + PRE_W'(1);
      end
   end

   // Slot state: occupancy, entry stamps and sticky wrap flags.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_occ  <= '0;
         r_wrap <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            r_stamp[i] <= '0;
         end
      end else begin
         // A full period has elapsed when the counter is about to return to the stamp.
         for (int i = 0; i < SLOTS; i++) begin
            if (w_tick && r_occ[i] && (w_now_inc == r_stamp[i])) begin
               r_wrap[i] <= 1'b1;
            end
         end
         if (w_exit_ok) begin
            r_occ[i_exit_slot] <= 1'b0;
         end
         // Placed after the exit update so a same-slot re-entry keeps the slot occupied.
         if (w_enter_ok) begin
            r_stamp[i_enter_slot] <= r_now;
            r_occ[i_enter_slot]   <= 1'b1;
            r_wrap[i_enter_slot]  <= 1'b0;
         end
      end
   end

   // Registered duration report and error pulse; dur fields hold when idle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_dur_valid <= 1'b0;
         r_dur_slot  <= '0;
         r_dur_time  <= '0;
         r_dur_wrap  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_dur_valid <= w_exit_ok;
         r_err       <= w_err;
         if (w_exit_ok) begin
            r_dur_slot <= i_exit_slot;
            r_dur_time <= w_dur;
            r_dur_wrap <= r_wrap[i_exit_slot];
         end
      end
   end

   assign o_now_time  = r_now;
   assign o_occupied  = r_occ;
   assign o_dur_valid = r_dur_valid;
   assign o_dur_slot  = r_dur_slot;
   assign o_dur_time  = r_dur_time;
   assign o_dur_wrap  = r_dur_wrap;
   assign o_err       = r_err;

endmodule
